// File: rtl/perip_pwm_pkg.sv
// Shared constants for the LED PWM / buzzer peripheral: parameter defaults,
// capture synchronizer depth and the slot order of the configuration words.
package perip_pwm_pkg;

    localparam int   CNT_W_DEF   = 32;
    localparam logic LED_POL_DEF = 1'b1;
    localparam int   SYNC_DEPTH  = 2;

    localparam int NUM_CFG = 5;
    localparam int NUM_LED = 3;

    // Slot order of the configuration words in the capture array
    localparam int CFG_LED_FREQ  = 0;
    localparam int CFG_BZ_FREQ   = 1;
    localparam int CFG_LEDR_DUTY = 2;
    localparam int CFG_LEDG_DUTY = 3;
    localparam int CFG_LEDB_DUTY = 4;

endpackage

// File: rtl/perip_cfg_sync.sv
// Stable-capture of one multi-bit configuration word arriving from another
// clock domain: the word is accepted only when two consecutive samples agree.
module perip_cfg_sync
    import perip_pwm_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] value
);

    logic [W-1:0] stage_reg [SYNC_DEPTH];
    logic [W-1:0] value_reg;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
            value_reg <= '0;
        end else begin
            stage_reg[0] <= raw;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
            // A word caught mid-transition differs from its neighbour sample,
            // so it can never be accepted.
            if (stage_reg[SYNC_DEPTH-1] == stage_reg[SYNC_DEPTH-2]) begin
                value_reg <= stage_reg[SYNC_DEPTH-1];
            end
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/perip_led_bz_pwm.sv
// Three-channel LED PWM with period-aligned duty updates, plus a square-wave
// buzzer driver; configuration words come from the flexbus clock domain.
module perip_led_bz_pwm
    import perip_pwm_pkg::*;
#(
    parameter int   CNT_W   = CNT_W_DEF,
    parameter logic LED_POL = LED_POL_DEF
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [CNT_W-1:0] LED_FREQ_Reg,
    input  logic [CNT_W-1:0] BZ_FREQ_Reg,
    input  logic [CNT_W-1:0] LEDR_Puty_Reg,
    input  logic [CNT_W-1:0] LEDG_Puty_Reg,
    input  logic [CNT_W-1:0] LEDB_Puty_Reg,
    output logic             LED_R,
    output logic             LED_G,
    output logic             LED_B,
    output logic             BZ_OUT,
    output logic             PERIOD_TICK
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cfg_raw [NUM_CFG];
    logic [CNT_W-1:0] cfg_acc [NUM_CFG];

    assign cfg_raw[CFG_LED_FREQ]  = LED_FREQ_Reg;
    assign cfg_raw[CFG_BZ_FREQ]   = BZ_FREQ_Reg;
    assign cfg_raw[CFG_LEDR_DUTY] = LEDR_Puty_Reg;
    assign cfg_raw[CFG_LEDG_DUTY] = LEDG_Puty_Reg;
    assign cfg_raw[CFG_LEDB_DUTY] = LEDB_Puty_Reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CFG; gi++) begin : g_sync
            perip_cfg_sync #(
                .W(CNT_W)
            ) u_sync (
                .CLK   (CLK),
                .RST_n (RST_n),
                .raw   (cfg_raw[gi]),
                .value (cfg_acc[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // LED PWM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   period_reg;
    logic [CNT_W-1:0]   duty_reg [NUM_LED];
    logic [CNT_W-1:0]   cnt_reg;
    logic               period_end;
    logic               shadow_load;
    logic [NUM_LED-1:0] led_on;
    logic [NUM_LED-1:0] led_reg;
    logic               tick_reg;

    assign period_end  = (period_reg != '0) && (cnt_reg == period_reg - CNT_ONE);
    // Shadows change only at a period boundary so a period never mixes two
    // settings; an idle (zero-period) channel picks up new values at once.
    assign shadow_load = period_end || (period_reg == '0);

    generate
        for (gi = 0; gi < NUM_LED; gi++) begin : g_led
            assign led_on[gi] = (period_reg != '0) && (cnt_reg < duty_reg[gi]);
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            period_reg <= '0;
            for (int i = 0; i < NUM_LED; i++) begin
                duty_reg[i] <= '0;
            end
            cnt_reg  <= '0;
            led_reg  <= {NUM_LED{~LED_POL}};
            tick_reg <= 1'b0;
        end else begin
            if (shadow_load) begin
                period_reg <= cfg_acc[CFG_LED_FREQ];
                for (int i = 0; i < NUM_LED; i++) begin
                    duty_reg[i] <= cfg_acc[CFG_LEDR_DUTY + i];
                end
            end

            if ((period_reg == '0) || period_end) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end

            // Outputs trail cnt by one cycle; the tick is delayed alongside
            // so it marks the last LED cycle of the period as seen outside.
            led_reg  <= led_on ^ {NUM_LED{~LED_POL}};
            tick_reg <= period_end;
        end
    end

    assign LED_R       = led_reg[0];
    assign LED_G       = led_reg[1];
    assign LED_B       = led_reg[2];
    assign PERIOD_TICK = tick_reg;

    // ------------------------------------------------------------------
    // Buzzer: runs on the live accepted half-period, not a shadow
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] half_period;
    logic [CNT_W-1:0] bz_cnt_reg;
    logic             bz_reg;

    assign half_period = cfg_acc[CFG_BZ_FREQ];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            bz_cnt_reg <= '0;
            bz_reg     <= 1'b0;
        end else if (half_period == '0) begin
            bz_cnt_reg <= '0;
            bz_reg     <= 1'b0;
        end else if (bz_cnt_reg >= half_period - CNT_ONE) begin
            // >= rather than == so a shrinking half-period cannot strand the
            // counter above the new limit.
            bz_cnt_reg <= '0;
            bz_reg     <= ~bz_reg;
        end else begin
            bz_cnt_reg <= bz_cnt_reg + CNT_ONE;
        end
    end

    assign BZ_OUT = bz_reg;

endmodule
